// File: rtl/wb_queue.sv
// Write-back queue: a small circular FIFO of {rd, data} register-file writes.
// The head commits to the register file every cycle while the queue is
// occupied. Pending entries can be forwarded to the rs/rt read ports.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_data,
    output logic                     RegWrite,
    output logic [4:0]               rd,
    output logic [31:0]              write_data,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [31:0]              fwd_data1,
    output logic [31:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;
    logic [AW-1:0] slot;

    // Handshake, commit and next-state; r0 writes are consumed but dropped.
    always_comb begin
        in_ready = (count_q < FULL_C);
        pop      = (count_q != '0);
        push     = in_valid && in_ready && (in_rd != 5'd0);

        RegWrite   = pop;
        rd         = pop ? mem_q[rd_ptr_q].rd   : 5'd0;
        write_data = pop ? mem_q[rd_ptr_q].data : 32'd0;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{rd: in_rd, data: in_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Forwarding: walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = 32'd0;
        fwd_data2 = 32'd0;
        slot      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q + AW'(k);
            if ((AW+1)'(k) < count_q) begin
                if (rs != 5'd0 && mem_q[slot].rd == rs) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = mem_q[slot].data;
                end
                if (rt != 5'd0 && mem_q[slot].rd == rt) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = mem_q[slot].data;
                end
            end
        end
    end

    assign count = count_q;

    // Pointers and occupancy; reset invalidates every entry at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never reset; validity comes from occupancy alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed vector table, hand sequences for reset and
// pointer wrap, then random traffic against a queue-based reference model.
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [4:0]  rs, rt;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
        .rs(rs), .rt(rt),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: pending writes, oldest at index 0.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        v;
        logic [4:0]  ird;
        logic [31:0] idat;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
        int          e_cnt;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] ird, input logic [31:0] idat,
                         input logic [4:0] prs, input logic [4:0] prt);
        in_valid = v; in_rd = ird; in_data = idat; rs = prs; rt = prt;
        #1;
    endtask

    // One rising edge: the model applies pop-then-push with pre-edge occupancy.
    task automatic edge_step();
        bit acc;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            if (mq.size() > 0) void'(mq.pop_front());
            if (acc && in_rd != 5'd0) mq.push_back('{rd: in_rd, data: in_data});
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic        h1, h2;
        logic [31:0] d1, d2;
        h1 = 0; h2 = 0; d1 = 0; d2 = 0;
        foreach (mq[i]) begin
            if (rs != 0 && mq[i].rd == rs) begin h1 = 1; d1 = mq[i].data; end
            if (rt != 0 && mq[i].rd == rt) begin h2 = 1; d2 = mq[i].data; end
        end
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
        chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(mq.size() != 0));
        chk({tag, ".rd"}, 32'(rd), mq.size() != 0 ? 32'(mq[0].rd) : 32'd0);
        chk({tag, ".write_data"}, write_data, mq.size() != 0 ? mq[0].data : 32'd0);
        chk({tag, ".fwd_hit1"}, 32'(fwd_hit1), 32'(h1));
        chk({tag, ".fwd_data1"}, fwd_data1, d1);
        chk({tag, ".fwd_hit2"}, 32'(fwd_hit2), 32'(h2));
        chk({tag, ".fwd_data2"}, fwd_data2, d2);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    endtask

    initial begin
        // Expected values are the outputs before the edge that applies the inputs.
        //            v  ird    idat           rs     rt     we  rd     wd             h1 d1             h2 d2             cnt
        vecs[0]  = '{1, 5'd5, 32'h0000_00AA, 5'd0, 5'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        vecs[1]  = '{0, 5'd0, 32'h0,         5'd5, 5'd0, 1, 5'd5, 32'h0000_00AA, 1, 32'h0000_00AA, 0, 32'h0,         1};
        vecs[2]  = '{0, 5'd0, 32'h0,         5'd5, 5'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        // Same rd twice: offered request is not forwarded, each commit in order.
        vecs[3]  = '{1, 5'd3, 32'h11,        5'd3, 5'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        vecs[4]  = '{1, 5'd3, 32'h22,        5'd3, 5'd0, 1, 5'd3, 32'h11,        1, 32'h11,        0, 32'h0,         1};
        vecs[5]  = '{0, 5'd0, 32'h0,         5'd3, 5'd0, 1, 5'd3, 32'h22,        1, 32'h22,        0, 32'h0,         1};
        vecs[6]  = '{0, 5'd0, 32'h0,         5'd3, 5'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        // r0 writes are consumed and dropped; rs=0 never hits.
        vecs[7]  = '{1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        vecs[8]  = '{0, 5'd0, 32'h0,         5'd0, 5'd0, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        // Both read ports forward the same pending entry.
        vecs[9]  = '{1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        vecs[10] = '{0, 5'd0, 32'h0,         5'd7, 5'd7, 1, 5'd7, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1};
        vecs[11] = '{0, 5'd0, 32'h0,         5'd7, 5'd7, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        // rt-only hit with a non-matching rs.
        vecs[12] = '{1, 5'd9, 32'h1234_5678, 5'd4, 5'd9, 0, 5'd0, 32'h0,         0, 32'h0,         0, 32'h0,         0};
        vecs[13] = '{0, 5'd0, 32'h0,         5'd4, 5'd9, 1, 5'd9, 32'h1234_5678, 0, 32'h0,         1, 32'h1234_5678, 1};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        check_model("reset");
        edge_step();
        edge_step();
        #2 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].ird, vecs[i].idat, vecs[i].rs, vecs[i].rt);
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("vec%0d.RegWrite", i), 32'(RegWrite), 32'(vecs[i].e_we));
            chk($sformatf("vec%0d.rd", i), 32'(rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d.write_data", i), write_data, vecs[i].e_wd);
            chk($sformatf("vec%0d.fwd_hit1", i), 32'(fwd_hit1), 32'(vecs[i].e_h1));
            chk($sformatf("vec%0d.fwd_data1", i), fwd_data1, vecs[i].e_d1);
            chk($sformatf("vec%0d.fwd_hit2", i), 32'(fwd_hit2), 32'(vecs[i].e_h2));
            chk($sformatf("vec%0d.fwd_data2", i), fwd_data2, vecs[i].e_d2);
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_cnt));
            edge_step();
        end
        drive(0, 0, 0, 0, 0);
        edge_step();

        // Ten back-to-back writes to rd=1..10 wrap the pointers several times.
        // Since the head drains every occupied cycle, push+pop holds count at 1
        // and the queue can never fill, so in_ready must stay high throughout.
        for (int i = 1; i <= 10; i++) begin
            drive(1, 5'(i), 32'(i * 32'h100), 0, 0);
            chk($sformatf("wrap%0d.in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("wrap%0d.count", i), 32'(count), (i == 1) ? 32'd0 : 32'd1);
            if (i > 1) begin
                chk($sformatf("wrap%0d.rd", i), 32'(rd), 32'(i - 1));
                chk($sformatf("wrap%0d.write_data", i), write_data, 32'((i - 1) * 32'h100));
            end
            edge_step();
        end
        drive(0, 0, 0, 0, 0);
        chk("wrap_last.rd", 32'(rd), 32'd10);
        chk("wrap_last.write_data", write_data, 32'hA00);
        edge_step();
        chk("wrap_drained.RegWrite", 32'(RegWrite), 32'd0);

        // Mid-cycle reset discards the pending entry immediately.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 32'hC0DE_0000 + 32'(i), 5'd22, 5'd22);
            edge_step();
        end
        drive(0, 0, 0, 5'd22, 5'd22);
        chk("pre_rst.RegWrite", 32'(RegWrite), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async.RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_async.count", 32'(count), 32'd0);
        chk("rst_async.rd", 32'(rd), 32'd0);
        chk("rst_async.fwd_hit1", 32'(fwd_hit1), 32'd0);
        chk("rst_async.fwd_data2", fwd_data2, 32'd0);
        chk("rst_async.in_ready", 32'(in_ready), 32'd1);
        mq.delete();
        edge_step();
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check_model($sformatf("post_rst%0d", i));
            chk($sformatf("post_rst%0d.RegWrite", i), 32'(RegWrite), 32'd0);
        end

        // Random traffic with small register indices to provoke forwarding hits.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            check_model($sformatf("rand%0d", n));
            edge_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
